// File: rtl/dt_pkg.sv
// Shared types and sizing for the two-pass distance-transform scan controller.
package dt_pkg;

  localparam int IMG_DIM_MAX = 128;
  localparam int PIX_W       = 14;
  localparam int STI_W       = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_TURN,
    ST_BWD,
    ST_FIN
  } dt_state_e;

  // ROM words pack 16 pixels with the lowest raster index in bit 15.
  function automatic logic [3:0] msb_bit_sel(input logic [3:0] lo);
    return 4'd15 - lo;
  endfunction

endpackage

// File: rtl/dt_scan_cnt.sv
// Up/down pixel index counter with synchronous load, enable and terminal flag.
module dt_scan_cnt
  import dt_pkg::*;
#(
  parameter logic [PIX_W-1:0] LAST = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [PIX_W-1:0] load_val,
  output logic [PIX_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + PIX_W'(1) : cnt - PIX_W'(1);
    end
  end

  // Terminal depends on direction: top of image going up, zero going down.
  assign term = up ? (cnt == LAST) : (cnt == '0);

endmodule

// File: rtl/dt_scan_ctrl.sv
// Two-pass raster scan controller: forward pass reads the binary image,
// backward pass re-reads the result RAM; addresses follow the pixel index.
module dt_scan_ctrl
  import dt_pkg::*;
#(
  parameter int IMG_DIM = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        pix_valid,
  output logic [13:0] pix_idx,
  output logic        edge_l,
  output logic        edge_r,
  output logic        edge_t,
  output logic        edge_b,
  output logic        sti_rd,
  output logic [9:0]  sti_addr,
  output logic [3:0]  bit_sel,
  output logic        res_rd,
  output logic        res_wr,
  output logic [13:0] res_addr
);

  localparam int               LOG2     = $clog2(IMG_DIM);
  localparam logic [PIX_W-1:0] LAST_IDX = PIX_W'(IMG_DIM * IMG_DIM - 1);
  localparam logic [PIX_W-1:0] LAST_RC  = PIX_W'(IMG_DIM - 1);

  dt_state_e        state;
  logic             scanning;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_up;
  logic             term;
  logic [PIX_W-1:0] row;
  logic [PIX_W-1:0] col;

  assign scanning  = (state == ST_FWD) || (state == ST_BWD);
  assign pix_valid = scanning && !stall;
  assign cnt_load  = (state == ST_IDLE) && start;
  assign cnt_up    = (state == ST_FWD);
  // The index parks on the terminal value so TURN and FIN see it unchanged.
  assign cnt_en    = pix_valid && !term;

  dt_scan_cnt #(
    .LAST(LAST_IDX)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .en      (cnt_en),
    .up      (cnt_up),
    .load_val('0),
    .cnt     (pix_idx),
    .term    (term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_FWD;
        ST_FWD:  if (pix_valid && term) state <= ST_TURN;
        ST_TURN: state <= ST_BWD;
        ST_BWD:  if (pix_valid && term) state <= ST_FIN;
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FIN);
  assign pass   = (state == ST_TURN) || (state == ST_BWD);
  assign sti_rd = pix_valid && (state == ST_FWD);
  assign res_rd = pix_valid && (state == ST_BWD);
  assign res_wr = pix_valid;

  // Upper index bits stay zero for small images, so row/col need no masking beyond this.
  assign row    = pix_idx >> LOG2;
  assign col    = pix_idx & LAST_RC;
  assign edge_l = (col == '0);
  assign edge_r = (col == LAST_RC);
  assign edge_t = (row == '0);
  assign edge_b = (row == LAST_RC);

  assign sti_addr = pix_idx[13:4];
  assign bit_sel  = msb_bit_sel(pix_idx[3:0]);
  assign res_addr = pix_idx;

endmodule

// File: tb/tb_dt_scan_ctrl.sv
// Scenario bench for dt_scan_ctrl at IMG_DIM=128 (dut_a) and IMG_DIM=16 (dut_b).
module tb_dt_scan_ctrl;

  localparam int BIG = 128;
  localparam int SML = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, stall_a;
  logic busy_a, done_a, pass_a, pv_a, el_a, er_a, et_a, eb_a, sti_rd_a, res_rd_a, res_wr_a;
  logic [13:0] pidx_a, res_addr_a;
  logic [9:0]  sti_addr_a;
  logic [3:0]  bit_sel_a;

  logic rst_b, start_b, stall_b;
  logic busy_b, done_b, pass_b, pv_b, el_b, er_b, et_b, eb_b, sti_rd_b, res_rd_b, res_wr_b;
  logic [13:0] pidx_b, res_addr_b;
  logic [9:0]  sti_addr_b;
  logic [3:0]  bit_sel_b;

  dt_scan_ctrl #(.IMG_DIM(BIG)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .stall(stall_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .pix_valid(pv_a), .pix_idx(pidx_a),
    .edge_l(el_a), .edge_r(er_a), .edge_t(et_a), .edge_b(eb_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .bit_sel(bit_sel_a),
    .res_rd(res_rd_a), .res_wr(res_wr_a), .res_addr(res_addr_a)
  );

  dt_scan_ctrl #(.IMG_DIM(SML)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .stall(stall_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .pix_valid(pv_b), .pix_idx(pidx_b),
    .edge_l(el_b), .edge_r(er_b), .edge_t(et_b), .edge_b(eb_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .bit_sel(bit_sel_b),
    .res_rd(res_rd_b), .res_wr(res_wr_b), .res_addr(res_addr_b)
  );

  int errors = 0;
  int checks = 0;

  // Expected pixel stream: bit 16 = pass, bits 13:0 = index.
  int q_a[$];
  int q_b[$];
  int sb_bad_a = 0;
  int sb_bad_b = 0;
  logic [31:0] e_a, e_b;

  task automatic push_frame(input int dim, input int stop, input bit to_b);
    for (int i = 0; i < dim * dim; i++) begin
      if (to_b) q_b.push_back(i); else q_a.push_back(i);
    end
    for (int i = dim * dim - 1; i >= stop; i--) begin
      if (to_b) q_b.push_back(32'h10000 | i); else q_a.push_back(32'h10000 | i);
    end
  endtask

  always @(negedge clk) begin
    if (pv_a) begin
      if (q_a.size() == 0) sb_bad_a++;
      else begin
        e_a = q_a.pop_front();
        if (pidx_a !== e_a[13:0] || pass_a !== e_a[16] || res_addr_a !== e_a[13:0] ||
            sti_addr_a !== e_a[13:4] || bit_sel_a !== 4'(15 - e_a[3:0]) ||
            sti_rd_a !== !e_a[16] || res_rd_a !== e_a[16] || res_wr_a !== 1'b1 || busy_a !== 1'b1)
          sb_bad_a++;
      end
    end else if (sti_rd_a || res_rd_a || res_wr_a) sb_bad_a++;
  end

  always @(negedge clk) begin
    if (pv_b) begin
      if (q_b.size() == 0) sb_bad_b++;
      else begin
        e_b = q_b.pop_front();
        if (pidx_b !== e_b[13:0] || pass_b !== e_b[16] || res_addr_b !== e_b[13:0] ||
            sti_addr_b !== e_b[13:4] || bit_sel_b !== 4'(15 - e_b[3:0]) ||
            sti_rd_b !== !e_b[16] || res_rd_b !== e_b[16] || res_wr_b !== 1'b1 || busy_b !== 1'b1)
          sb_bad_b++;
      end
    end else if (sti_rd_b || res_rd_b || res_wr_b) sb_bad_b++;
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_busy_done_a: got busy=%b done=%b want 0 0", busy_a, done_a); end
    checks++; if (pidx_a !== 14'd0 || pass_a !== 1'b0) begin errors++; $display("FAIL reset_idx_pass_a: got idx=%0d pass=%b want 0 0", pidx_a, pass_a); end
    checks++; if ({pv_a, sti_rd_a, res_rd_a, res_wr_a} !== 4'b0) begin errors++; $display("FAIL reset_strobes_a: got %b want 0000", {pv_a, sti_rd_a, res_rd_a, res_wr_a}); end
    checks++; if ({busy_b, done_b, pv_b, res_wr_b} !== 4'b0 || pidx_b !== 14'd0) begin errors++; $display("FAIL reset_b: got %b idx=%0d want 0000 idx=0", {busy_b, done_b, pv_b, res_wr_b}, pidx_b); end
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy_a=%b busy_b=%b want 0 0", busy_a, busy_b); end
  endtask

  task automatic test_small_dim();
    int n, fwd_v, hi_bad, done_cyc;
    logic busy_after;
    logic [3:0] e15, e16, e255;
    n = 1; fwd_v = 0; hi_bad = 0; done_cyc = 0; busy_after = 1'bx;
    e15 = 'x; e16 = 'x; e255 = 'x;
    push_frame(SML, 0, 1'b1);
    @(posedge clk); #1;
    start_b = 1'b1;
    while (n <= 1000) begin
      @(negedge clk);
      if (pidx_b[13:8] !== 6'd0) hi_bad++;
      if (pv_b && !pass_b) begin
        fwd_v++;
        if (pidx_b == 14'd15)  e15  = {el_b, er_b, et_b, eb_b};
        if (pidx_b == 14'd16)  e16  = {el_b, er_b, et_b, eb_b};
        if (pidx_b == 14'd255) e255 = {el_b, er_b, et_b, eb_b};
      end
      if (done_b && done_cyc == 0) done_cyc = n;
      if (done_cyc != 0 && n == done_cyc + 1) begin busy_after = busy_b; break; end
      @(posedge clk); #1;
      start_b = 1'b0;
      n++;
    end
    start_b = 1'b0;
    checks++; if (fwd_v != 256) begin errors++; $display("FAIL small_fwd_count: got %0d want 256", fwd_v); end
    checks++; if (hi_bad != 0) begin errors++; $display("FAIL small_upper_bits: got %0d nonzero cycles want 0", hi_bad); end
    checks++; if (done_cyc != 515) begin errors++; $display("FAIL small_done_cycle: got %0d want 515", done_cyc); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL small_busy_after: got %b want 0", busy_after); end
    checks++; if ({e15, e16, e255} !== {4'b0110, 4'b1000, 4'b0101}) begin errors++; $display("FAIL small_edges: got %b %b %b want 0110 1000 0101", e15, e16, e255); end
    checks++; if (sb_bad_b != 0 || q_b.size() != 0) begin errors++; $display("FAIL small_stream: got bad=%0d left=%0d want 0 0", sb_bad_b, q_b.size()); end
  endtask

  // start held high throughout, a 5-cycle stall early in FWD, and the
  // follow-on frame aborted by reset when BWD reaches index 9000.
  task automatic test_stall_hold_reset();
    int n, frz, dcnt, done_cyc;
    logic b1, b2, pv2, hit;
    logic [13:0] idx2;
    n = 1; frz = 0; dcnt = 0; done_cyc = 0; hit = 1'b0;
    b1 = 1'bx; b2 = 1'bx; pv2 = 1'bx; idx2 = 'x;
    push_frame(BIG, 0, 1'b0);
    push_frame(BIG, 9000, 1'b0);
    @(posedge clk); #1;
    start_a = 1'b1;
    while (n <= 60000) begin
      @(negedge clk);
      if (busy_a && !pass_a && !pv_a && pidx_a == 14'd5) frz++;
      if (done_a) begin dcnt++; if (done_cyc == 0) done_cyc = n; end
      if (done_cyc != 0 && n == done_cyc + 1) b1 = busy_a;
      if (done_cyc != 0 && n == done_cyc + 2) begin b2 = busy_a; pv2 = pv_a; idx2 = pidx_a; end
      if (done_cyc != 0 && pass_a && pv_a && pidx_a == 14'd9000) begin hit = 1'b1; break; end
      @(posedge clk); #1;
      n++;
      stall_a = (n >= 7 && n <= 11);
    end
    #2;
    rst_a = 1'b1; start_a = 1'b0; stall_a = 1'b0;
    #1;
    checks++; if (frz != 5) begin errors++; $display("FAIL stall_frozen: got %0d cycles want 5", frz); end
    checks++; if (done_cyc != 32776) begin errors++; $display("FAIL stall_frame_len: got %0d want 32776", done_cyc); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL hold_done_count: got %0d want 1", dcnt); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL hold_idle_gap: got busy=%b want 0", b1); end
    checks++; if ({b2, pv2} !== 2'b11 || idx2 !== 14'd0) begin errors++; $display("FAIL hold_restart: got busy=%b valid=%b idx=%0d want 1 1 0", b2, pv2, idx2); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_point_reached: got %b want 1", hit); end
    checks++; if ({busy_a, res_wr_a, pv_a, pass_a, done_a} !== 5'b0) begin errors++; $display("FAIL mid_reset_ctrl: got %b want 00000", {busy_a, res_wr_a, pv_a, pass_a, done_a}); end
    checks++; if (pidx_a !== 14'd0) begin errors++; $display("FAIL mid_reset_idx: got %0d want 0", pidx_a); end
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b want 0", busy_a); end
    checks++; if (sb_bad_a != 0 || q_a.size() != 0) begin errors++; $display("FAIL stall_stream: got bad=%0d left=%0d want 0 0", sb_bad_a, q_a.size()); end
    sb_bad_a = 0;
  endtask

  task automatic test_full_frame();
    int n, vcnt, dcnt, done_cyc, turn_cyc, turn_v;
    logic [13:0] first_bwd, f_idx;
    logic [9:0]  f_sa;
    logic [3:0]  f_bs, e127, e128, e16383;
    logic        f_pv, busy_after;
    n = 1; vcnt = 0; dcnt = 0; done_cyc = 0; turn_cyc = 0; turn_v = -1;
    first_bwd = 'x; f_idx = 'x; f_sa = 'x; f_bs = 'x; f_pv = 1'bx; busy_after = 1'bx;
    e127 = 'x; e128 = 'x; e16383 = 'x;
    push_frame(BIG, 0, 1'b0);
    @(posedge clk); #1;
    start_a = 1'b1;
    while (n <= 40000) begin
      @(negedge clk);
      if (n == 2) begin f_pv = pv_a; f_idx = pidx_a; f_sa = sti_addr_a; f_bs = bit_sel_a; end
      if (busy_a && pass_a && !pv_a && turn_cyc == 0) begin turn_cyc = n; turn_v = vcnt; end
      if (turn_cyc != 0 && n == turn_cyc + 1) first_bwd = pidx_a;
      if (pv_a) vcnt++;
      if (pv_a && !pass_a) begin
        if (pidx_a == 14'd127)   e127   = {el_a, er_a, et_a, eb_a};
        if (pidx_a == 14'd128)   e128   = {el_a, er_a, et_a, eb_a};
        if (pidx_a == 14'd16383) e16383 = {el_a, er_a, et_a, eb_a};
      end
      if (done_a) begin dcnt++; if (done_cyc == 0) done_cyc = n; end
      if (done_cyc != 0 && n == done_cyc + 1) begin busy_after = busy_a; break; end
      @(posedge clk); #1;
      start_a = 1'b0;
      n++;
    end
    start_a = 1'b0;
    checks++; if (f_pv !== 1'b1 || f_idx !== 14'd0) begin errors++; $display("FAIL first_fwd: got valid=%b idx=%0d want 1 0", f_pv, f_idx); end
    checks++; if (f_sa !== 10'd0 || f_bs !== 4'd15) begin errors++; $display("FAIL first_fwd_addr: got addr=%0d bit=%0d want 0 15", f_sa, f_bs); end
    checks++; if (turn_v != 16384) begin errors++; $display("FAIL turn_after: got %0d valid cycles want 16384", turn_v); end
    checks++; if (first_bwd !== 14'd16383) begin errors++; $display("FAIL first_bwd: got %0d want 16383", first_bwd); end
    checks++; if (done_cyc != 32771 || dcnt != 1) begin errors++; $display("FAIL done_cycle: got %0d (pulses %0d) want 32771 (1)", done_cyc, dcnt); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_drop: got %b want 0", busy_after); end
    checks++; if (e127 !== 4'b0110) begin errors++; $display("FAIL edges_127: got lrtb=%b want 0110", e127); end
    checks++; if (e128 !== 4'b1000) begin errors++; $display("FAIL edges_128: got lrtb=%b want 1000", e128); end
    checks++; if (e16383 !== 4'b0101) begin errors++; $display("FAIL edges_16383: got lrtb=%b want 0101", e16383); end
    checks++; if (sb_bad_a != 0 || q_a.size() != 0) begin errors++; $display("FAIL full_stream: got bad=%0d left=%0d want 0 0", sb_bad_a, q_a.size()); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; start_a = 1'b0; stall_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; stall_b = 1'b0;
    test_reset();
    test_small_dim();
    test_stall_hold_reset();
    test_full_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dt_scan_ctrl.md
DT_SCAN_CTRL -- requirements
Module: dt_scan_ctrl

Interface
REQ-001 Parameter: IMG_DIM, default 128, meaning image side in pixels; must be a power of two, 16..128.
REQ-002 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begins one two-pass frame when IDLE.
- stall  in  1  engine or memory not ready; freezes the scan.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- pass  out  1  0 = forward pass, 1 = backward pass.
- pix_valid  out  1  current pixel index is being issued this cycle.
- pix_idx  out  14  raster pixel index, row*IMG_DIM+col.
- edge_l  out  1  col==0.
- edge_r  out  1  col==IMG_DIM-1.
- edge_t  out  1  row==0.
- edge_b  out  1  row==IMG_DIM-1.
- sti_rd  out  1  binary-image ROM read strobe.
- sti_addr  out  10  ROM word address, pix_idx[13:4].
- bit_sel  out  4  pixel bit within word; MSB-first, bit 15-pix_idx[3:0].
- res_rd  out  1  result RAM read strobe.
- res_wr  out  1  result RAM write strobe.
- res_addr  out  14  result RAM byte address, equal to pix_idx.

Function
REQ-003 States: IDLE, FWD, TURN, BWD, FIN; encoding is internal.
REQ-004 IDLE: start=1 -> FWD on next edge, pix_idx=0; start during any other state is ignored.
REQ-005 FWD: each non-stalled cycle asserts pix_valid, sti_rd and res_wr, then increments pix_idx by 1; res_rd=0; pass=0.
REQ-006 FWD at pix_idx=IMG_DIM*IMG_DIM-1, non-stalled -> TURN; pix_idx holds.
REQ-007 TURN: exactly one cycle with all strobes 0, pass=1, then BWD with pix_idx=IMG_DIM*IMG_DIM-1.
REQ-008 BWD: each non-stalled cycle asserts pix_valid, res_rd and res_wr, then decrements pix_idx by 1; sti_rd=0.
REQ-009 BWD at pix_idx=0, non-stalled -> FIN.
REQ-010 FIN: one cycle with done=1 and strobes 0, then IDLE; done is high only in FIN.
REQ-011 busy=1 in FWD, TURN, BWD and FIN; busy=0 in IDLE.
REQ-012 stall=1 in FWD or BWD: pix_valid, sti_rd, res_rd and res_wr are 0; pix_idx and state hold; addresses stay stable.
REQ-013 stall has no effect in IDLE, TURN or FIN.
REQ-014 Strobes, addresses and edge flags are combinational from registered state and pix_idx, and are valid in the same cycle as pix_valid; no added latency.
REQ-015 Row/col derivation is row=pix_idx>>log2(IMG_DIM), col=pix_idx&(IMG_DIM-1); unused upper pix_idx bits for IMG_DIM<128 are 0.
REQ-016 Counter arithmetic is unsigned 14-bit; no wrap occurs, because terminal indices force the state change first.
REQ-017 A frame with no stalls takes exactly 2*IMG_DIM*IMG_DIM+3 cycles from the start-accept edge to the end of the done cycle.

Reset
REQ-018 Assertion of reset at any time, including mid-pass, forces IDLE, pix_idx=0, pass=0, and busy, done, pix_valid and all strobes to 0; no partial frame resumes.
REQ-019 After reset deasserts, the first start is accepted normally.

Structure
REQ-020 A shared package dt_pkg holds the state enumeration, IMG_DIM_MAX=128, PIX_W=14 and STI_W=10.
REQ-021 One sub-module, dt_scan_cnt, is natural: an up/down index counter with load, enable and terminal-count output. The FSM stays in dt_scan_ctrl.

Verification
REQ-022 The bench shall cover these directed scenarios:
- IMG_DIM=128, start pulse, no stall -> first FWD cycle pix_idx=0, sti_addr=0, bit_sel=15; TURN seen after 16384 valid cycles; first BWD pix_idx=16383; done pulse at cycle 32771; busy drops the next cycle.
- IMG_DIM=128, stall=1 for cycles 5..9 of FWD -> pix_valid=0 and pix_idx frozen at 5 for 5 cycles; total frame length 32776 cycles.
- Edge flags at pix_idx=127 -> edge_r=1, edge_t=1; at pix_idx=128 -> edge_l=1; at pix_idx=16383 -> edge_r=1, edge_b=1.
- start held high through the whole frame -> exactly one frame runs; a second frame starts only on the first IDLE cycle after FIN.
- reset asserted in BWD at pix_idx=9000 -> same edge: busy=0, res_wr=0, pix_idx=0; a new start gives a full 32771-cycle frame.
- IMG_DIM=16 -> 256 forward indices; pix_idx[13:8]=0 throughout; done at cycle 515.
